// File: rtl/hazard_controller.sv
// hazard_controller
//   Pipeline sequencing controller for the five-stage RV32I core.
//   Produces the EX-stage forwarding selects, the per-stage register load
//   and flush controls, tracks freeze / bubble sequencing and keeps
//   wrap-around performance counters.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal flow, nothing pending
// FREEZE| a memory wait stalled every stage last cycle
// BUBBLE| a load-use bubble was inserted into EX last cycle
//
// Ports
//   clk, rst                          clock, async active-high reset
//   id_rs1/id_rs2, ex_rs1/ex_rs2      source registers in ID and EX
//   ex_rd/mem_rd/wb_rd (+ *_load_regfile) destinations per stage
//   ex_is_load, ex_br_taken           EX instruction kind / redirect
//   wb_valid                          WB holds a real instruction
//   imem_*/dmem_*                     memory handshakes
//   forwarded_alumux{1,2}_sel         00 regfile, 01 EX/MEM, 10 WB
//   load_*, flush_*                   pipeline register controls
//   perf_*                            event counters
//   state_o                           current FSM state
module hazard_controller #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       ex_rs1,
   input  logic [4:0]       ex_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_load_regfile,
   input  logic             ex_is_load,
   input  logic             ex_br_taken,
   input  logic [4:0]       mem_rd,
   input  logic             mem_load_regfile,
   input  logic [4:0]       wb_rd,
   input  logic             wb_load_regfile,
   input  logic             wb_valid,
   input  logic             imem_read,
   input  logic             imem_resp,
   input  logic             dmem_read,
   input  logic             dmem_write,
   input  logic             dmem_resp,
   output logic [1:0]       forwarded_alumux1_sel,
   output logic [1:0]       forwarded_alumux2_sel,
   output logic             load_pc,
   output logic             load_if_id,
   output logic             load_id_ex,
   output logic             load_ex_mem,
   output logic             load_mem_wb,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic [CNT_W-1:0] perf_mem_stall,
   output logic [CNT_W-1:0] perf_load_use,
   output logic [CNT_W-1:0] perf_flush,
   output logic [CNT_W-1:0] perf_retired,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      RUN    = 2'b00,
      FREEZE = 2'b01,
      BUBBLE = 2'b10
   } state_t;

   state_t state, state_nx;
   logic   mem_wait;
   logic   lu;
   logic   do_bubble;
   logic   do_flush;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      // MEM beats WB because it holds the younger value; x0 never forwards.
      if (mem_load_regfile && (mem_rd != 5'd0) && (mem_rd == rs))
         return 2'b01;
      else if (wb_load_regfile && (wb_rd != 5'd0) && (wb_rd == rs))
         return 2'b10;
      else
         return 2'b00;
   endfunction

   assign mem_wait = (imem_read & ~imem_resp) |
                     ((dmem_read | dmem_write) & ~dmem_resp);

   assign lu = ex_is_load & ex_load_regfile & (ex_rd != 5'd0) &
               ((ex_rd == id_rs1) | (ex_rd == id_rs2));

   // A taken branch flushes the dependent ID instruction, so it suppresses
   // the bubble. While frozen the branch stays parked in EX and flushes on
   // the first cycle the wait clears.
   assign do_flush  = ~mem_wait & ex_br_taken;
   assign do_bubble = ~mem_wait & ~ex_br_taken & lu;

   always_comb begin
      forwarded_alumux1_sel = 2'b00;
      forwarded_alumux2_sel = 2'b00;
      if (!rst) begin
         forwarded_alumux1_sel = fwd_sel(ex_rs1);
         forwarded_alumux2_sel = fwd_sel(ex_rs2);
      end
   end

   always_comb begin
      load_pc     = 1'b1;
      load_if_id  = 1'b1;
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      if (rst) begin
         load_pc     = 1'b0;
         load_if_id  = 1'b0;
         load_id_ex  = 1'b0;
         load_ex_mem = 1'b0;
         load_mem_wb = 1'b0;
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end else if (mem_wait) begin
         load_pc     = 1'b0;
         load_if_id  = 1'b0;
         load_id_ex  = 1'b0;
         load_ex_mem = 1'b0;
         load_mem_wb = 1'b0;
      end else if (ex_br_taken) begin
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end else if (lu) begin
         load_pc     = 1'b0;
         load_if_id  = 1'b0;
         flush_id_ex = 1'b1;
      end
   end

   always_comb begin
      state_nx = RUN;
      if (mem_wait)
         state_nx = FREEZE;
      else if (lu && !ex_br_taken)
         state_nx = BUBBLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= RUN;
      else
         state <= state_nx;
   end

   assign state_o = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_mem_stall <= '0;
         perf_load_use  <= '0;
         perf_flush     <= '0;
         perf_retired   <= '0;
      end else begin
         if (mem_wait)
            perf_mem_stall <= perf_mem_stall + CNT_W'(1);
         if (do_bubble)
            perf_load_use <= perf_load_use + CNT_W'(1);
         if (do_flush)
            perf_flush <= perf_flush + CNT_W'(1);
         // load_mem_wb is low during a stall, so a frozen WB counts once.
         if (wb_valid && load_mem_wb)
            perf_retired <= perf_retired + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic        ex_load_regfile, ex_is_load, ex_br_taken;
   logic        mem_load_regfile, wb_load_regfile, wb_valid;
   logic        imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;
   logic [1:0]  fwd1, fwd2;
   logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
   logic        flush_if_id, flush_id_ex;
   logic [31:0] perf_mem_stall, perf_load_use, perf_flush, perf_retired;
   logic [1:0]  state_o;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   hazard_controller #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_load_regfile(ex_load_regfile), .ex_is_load(ex_is_load),
      .ex_br_taken(ex_br_taken), .mem_rd(mem_rd), .mem_load_regfile(mem_load_regfile),
      .wb_rd(wb_rd), .wb_load_regfile(wb_load_regfile), .wb_valid(wb_valid),
      .imem_read(imem_read), .imem_resp(imem_resp), .dmem_read(dmem_read),
      .dmem_write(dmem_write), .dmem_resp(dmem_resp),
      .forwarded_alumux1_sel(fwd1), .forwarded_alumux2_sel(fwd2),
      .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
      .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
      .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
      .perf_mem_stall(perf_mem_stall), .perf_load_use(perf_load_use),
      .perf_flush(perf_flush), .perf_retired(perf_retired), .state_o(state_o)
   );

   // ex_f = {ex_load_regfile, ex_is_load, ex_br_taken}
   // mctl = {imem_read, imem_resp, dmem_read, dmem_write, dmem_resp}
   // e_ld = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}
   // e_fl = {flush_if_id, flush_id_ex}
   typedef struct {
      logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
      logic [2:0] ex_f;
      logic [4:0] mem_rd;
      logic       mem_lr;
      logic [4:0] wb_rd;
      logic       wb_lr;
      logic [4:0] mctl;
      logic [1:0] e_f1, e_f2;
      logic [4:0] e_ld;
      logic [1:0] e_fl;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_ctl(input string name, input logic [4:0] ld, input logic [1:0] fl);
      chk({name, ".load"}, 32'({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}), 32'(ld));
      chk({name, ".flush"}, 32'({flush_if_id, flush_id_ex}), 32'(fl));
   endtask

   task automatic idle();
      id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
      ex_load_regfile = 0; ex_is_load = 0; ex_br_taken = 0;
      mem_rd = 0; mem_load_regfile = 0; wb_rd = 0; wb_load_regfile = 0;
      wb_valid = 0; imem_read = 0; imem_resp = 0;
      dmem_read = 0; dmem_write = 0; dmem_resp = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_lu();
      ex_is_load = 1; ex_load_regfile = 1; ex_rd = 7; id_rs2 = 7;
   endtask

   initial begin
      vecs[0]  = '{0,0,5,0,0,3'b000,5,1,5,1,5'b00000, 2'b01,2'b00,5'b11111,2'b00};
      vecs[1]  = '{0,0,5,0,0,3'b000,5,0,5,1,5'b00000, 2'b10,2'b00,5'b11111,2'b00};
      vecs[2]  = '{0,0,0,0,0,3'b000,0,1,0,1,5'b00000, 2'b00,2'b00,5'b11111,2'b00};
      vecs[3]  = '{0,0,3,9,0,3'b000,9,0,9,1,5'b00000, 2'b00,2'b10,5'b11111,2'b00};
      vecs[4]  = '{0,0,4,4,0,3'b000,4,1,0,0,5'b00000, 2'b01,2'b01,5'b11111,2'b00};
      vecs[5]  = '{0,7,0,0,7,3'b110,0,0,0,0,5'b00000, 2'b00,2'b00,5'b00111,2'b01};
      vecs[6]  = '{0,0,0,0,0,3'b110,0,0,0,0,5'b00000, 2'b00,2'b00,5'b11111,2'b00};
      vecs[7]  = '{7,0,0,0,7,3'b010,0,0,0,0,5'b00000, 2'b00,2'b00,5'b11111,2'b00};
      vecs[8]  = '{7,0,0,0,7,3'b111,0,0,0,0,5'b00000, 2'b00,2'b00,5'b11111,2'b11};
      vecs[9]  = '{0,0,0,0,0,3'b000,0,0,0,0,5'b00010, 2'b00,2'b00,5'b00000,2'b00};
      vecs[10] = '{0,0,0,0,0,3'b001,0,0,0,0,5'b10000, 2'b00,2'b00,5'b00000,2'b00};
      vecs[11] = '{0,0,0,0,0,3'b000,0,0,0,0,5'b11101, 2'b00,2'b00,5'b11111,2'b00};

      // reset state, with a forwarding match present that must be masked
      idle();
      rst = 1;
      ex_rs1 = 5; mem_rd = 5; mem_load_regfile = 1;
      #1;
      chk("rst.fwd1", 32'(fwd1), 0);
      chk("rst.state", 32'(state_o), 0);
      chk("rst.cnt", perf_mem_stall | perf_load_use | perf_flush | perf_retired, 0);
      chk_ctl("rst", 5'b00000, 2'b11);
      @(negedge clk);
      rst = 0;

      foreach (vecs[i]) begin
         @(negedge clk);
         id_rs1 = vecs[i].id_rs1; id_rs2 = vecs[i].id_rs2;
         ex_rs1 = vecs[i].ex_rs1; ex_rs2 = vecs[i].ex_rs2; ex_rd = vecs[i].ex_rd;
         {ex_load_regfile, ex_is_load, ex_br_taken} = vecs[i].ex_f;
         mem_rd = vecs[i].mem_rd; mem_load_regfile = vecs[i].mem_lr;
         wb_rd = vecs[i].wb_rd; wb_load_regfile = vecs[i].wb_lr;
         {imem_read, imem_resp, dmem_read, dmem_write, dmem_resp} = vecs[i].mctl;
         #2;
         chk($sformatf("vec%0d.fwd1", i), 32'(fwd1), 32'(vecs[i].e_f1));
         chk($sformatf("vec%0d.fwd2", i), 32'(fwd2), 32'(vecs[i].e_f2));
         chk_ctl($sformatf("vec%0d", i), vecs[i].e_ld, vecs[i].e_fl);
      end

      // fresh counters for the sequences
      @(negedge clk);
      idle();
      rst = 1;
      #2;
      rst = 0;

      // load-use: one bubble, BUBBLE for one cycle, then RUN
      drive_lu();
      #1;
      chk_ctl("lu", 5'b00111, 2'b01);
      tick();
      chk("lu.state", 32'(state_o), 2);
      chk("lu.count", perf_load_use, 1);
      idle();
      #1;
      chk_ctl("lu.after", 5'b11111, 2'b00);
      tick();
      chk("lu.state2", 32'(state_o), 0);

      // data wait of four cycles
      dmem_read = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("dwait%0d", i), 32'({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}), 0);
         tick();
         chk($sformatf("dwait%0d.state", i), 32'(state_o), 1);
      end
      dmem_resp = 1;
      #1;
      chk_ctl("dresp", 5'b11111, 2'b00);
      tick();
      chk("dresp.stall", perf_mem_stall, 4);
      chk("dresp.state", 32'(state_o), 0);
      idle();

      // taken branch held through a three-cycle fetch wait
      ex_br_taken = 1; imem_read = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk_ctl($sformatf("brfrz%0d", i), 5'b00000, 2'b00);
         tick();
      end
      imem_resp = 1;
      #1;
      chk_ctl("brfrz.go", 5'b11111, 2'b11);
      tick();
      chk("brfrz.flush", perf_flush, 1);
      chk("brfrz.stall", perf_mem_stall, 7);
      idle();

      // branch and load-use together: flush only
      drive_lu();
      ex_br_taken = 1;
      #1;
      chk_ctl("brlu", 5'b11111, 2'b11);
      tick();
      chk("brlu.lu", perf_load_use, 1);
      chk("brlu.flush", perf_flush, 2);
      chk("brlu.state", 32'(state_o), 0);
      idle();

      // retirement: two real cycles, one stalled cycle not counted
      wb_valid = 1;
      tick();
      tick();
      dmem_read = 1;
      tick();
      chk("ret.count", perf_retired, 2);
      chk("ret.stall", perf_mem_stall, 8);
      chk("ret.state", 32'(state_o), 1);

      // asynchronous reset mid-freeze, between edges
      ex_rs1 = 5; mem_rd = 5; mem_load_regfile = 1;
      #2;
      rst = 1;
      #1;
      chk("arst.state", 32'(state_o), 0);
      chk("arst.stall", perf_mem_stall, 0);
      chk("arst.ret", perf_retired, 0);
      chk("arst.flushcnt", perf_flush, 0);
      chk("arst.fwd1", 32'(fwd1), 0);
      chk_ctl("arst", 5'b00000, 2'b11);
      #1;
      rst = 0;
      idle();
      tick();
      chk("arst.after", 32'(state_o), 0);
      chk_ctl("arst.run", 5'b11111, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
